// File: rtl/seq_counter_ctrl.sv
// -----------------------------------------------------------------------------
// seq_counter_ctrl
//
// Timing sequence controller feeding the 4-to-16 timing decoder. Generates the
// sequence count `sc` (decoded downstream into one-hot T0..T15), with run,
// halt and single-step control, clear-on-instruction-end, and saturating
// cycle/instruction counters for debug and CPI measurement.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   IDLE: begin from T0 (clears counters); HALT: resume
//   halt       in   stop advancing and hold `sc` (ignored in IDLE)
//   sc_clr     in   end of instruction: next advance sets `sc` to 0
//   step_mode  in   1 = advance only on a `step_req` rising edge
//   step_req   in   single-step request level from the debug host
//   step_ack   out  one-cycle pulse after each stepped advance
//   sc         out  current timing state (decoder A input)
//   running    out  controller is in RUN
//   halted     out  controller is in HALT
//   sc_wrap    out  one-cycle pulse when `sc` wrapped MAX_T -> 0 by increment
//   cycle_cnt  out  advances since start, saturating
//   instr_cnt  out  accepted `sc_clr` events since start, saturating
// -----------------------------------------------------------------------------
module seq_counter_ctrl #(
    parameter int SC_WIDTH  = 4,
    parameter int MAX_T     = 15,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 sc_clr,
    input  logic                 step_mode,
    input  logic                 step_req,
    output logic                 step_ack,
    output logic [SC_WIDTH-1:0]  sc,
    output logic                 running,
    output logic                 halted,
    output logic                 sc_wrap,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [SC_WIDTH-1:0] LAST_SC = SC_WIDTH'(MAX_T);

    state_t                 state;
    state_t                 state_next;
    logic                   step_req_q;
    logic                   advance;
    logic [SC_WIDTH-1:0]    sc_next;
    logic                   step_ack_next;
    logic                   sc_wrap_next;
    logic [CNT_WIDTH-1:0]   cycle_next;
    logic [CNT_WIDTH-1:0]   instr_next;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    // In step mode only the first cycle of a high `step_req` level counts, so
    // holding the request yields a single advance.
    assign advance = !step_mode || (step_req && !step_req_q);

    // Next-state and next-output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        state_next    = state;
        sc_next       = sc;
        cycle_next    = cycle_cnt;
        instr_next    = instr_cnt;
        step_ack_next = 1'b0;
        sc_wrap_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    sc_next    = '0;
                    cycle_next = '0;
                    instr_next = '0;
                end
            end

            RUN: begin
                // halt wins over everything, even a pending advance.
                if (halt) begin
                    state_next = HALT;
                end else if (advance) begin
                    step_ack_next = step_mode;
                    cycle_next    = sat_inc(cycle_cnt);
                    if (sc_clr) begin
                        sc_next    = '0;
                        instr_next = sat_inc(instr_cnt);
                    end else if (sc == LAST_SC) begin
                        sc_next      = '0;
                        sc_wrap_next = 1'b1;
                    end else begin
                        sc_next = sc + SC_WIDTH'(1);
                    end
                end
            end

            HALT: begin
                // Resume keeps the held `sc` and counters.
                if (start && !halt) begin
                    state_next = RUN;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs and the step-request edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_req_q <= 1'b0;
            sc         <= '0;
            step_ack   <= 1'b0;
            sc_wrap    <= 1'b0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            step_req_q <= step_req;
            sc         <= sc_next;
            step_ack   <= step_ack_next;
            sc_wrap    <= sc_wrap_next;
            cycle_cnt  <= cycle_next;
            instr_cnt  <= instr_next;
            running    <= (state_next == RUN);
            halted     <= (state_next == HALT);
        end
    end

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_counter_ctrl
//
// Directed bench for seq_counter_ctrl. A behavioural model advances on every
// rising edge from the applied inputs and pushes its expected outputs into a
// queue; the entry is popped and compared against the DUT on the falling edge.
// A second instance with CNT_WIDTH = 4 shares the stimulus to exercise counter
// saturation.
// -----------------------------------------------------------------------------
module tb_seq_counter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        sc_clr;
    logic        step_mode;
    logic        step_req;

    logic        step_ack;
    logic [3:0]  sc;
    logic        running;
    logic        halted;
    logic        sc_wrap;
    logic [15:0] cycle_cnt;
    logic [15:0] instr_cnt;

    logic        step_ack4;
    logic [3:0]  sc4;
    logic        running4;
    logic        halted4;
    logic        sc_wrap4;
    logic [3:0]  cycle_cnt4;
    logic [3:0]  instr_cnt4;

    seq_counter_ctrl #(.SC_WIDTH(4), .MAX_T(15), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .halt      (halt),
        .sc_clr    (sc_clr),
        .step_mode (step_mode),
        .step_req  (step_req),
        .step_ack  (step_ack),
        .sc        (sc),
        .running   (running),
        .halted    (halted),
        .sc_wrap   (sc_wrap),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    seq_counter_ctrl #(.SC_WIDTH(4), .MAX_T(15), .CNT_WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .halt      (halt),
        .sc_clr    (sc_clr),
        .step_mode (step_mode),
        .step_req  (step_req),
        .step_ack  (step_ack4),
        .sc        (sc4),
        .running   (running4),
        .halted    (halted4),
        .sc_wrap   (sc_wrap4),
        .cycle_cnt (cycle_cnt4),
        .instr_cnt (instr_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_t;

    typedef struct packed {
        logic [3:0]  sc;
        logic        ack;
        logic        wrap;
        logic        run;
        logic        hlt;
        logic [15:0] cyc;
        logic [15:0] ins;
        logic [3:0]  cyc4;
        logic [3:0]  ins4;
    } exp_t;

    exp_t        exp_q[$];

    mstate_t     m_state;
    logic [3:0]  m_sc;
    logic        m_ack;
    logic        m_wrap;
    logic        m_req_q;
    logic [15:0] m_cyc;
    logic [15:0] m_ins;
    logic [3:0]  m_cyc4;
    logic [3:0]  m_ins4;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wrap_seen;
    int n_ack_seen;

    task automatic model_reset();
        m_state = M_IDLE;
        m_sc    = 4'd0;
        m_ack   = 1'b0;
        m_wrap  = 1'b0;
        m_req_q = 1'b0;
        m_cyc   = 16'd0;
        m_ins   = 16'd0;
        m_cyc4  = 4'd0;
        m_ins4  = 4'd0;
    endtask

    task automatic model_step();
        logic edge_seen;
        logic adv;
        edge_seen = step_req && !m_req_q;
        m_req_q   = step_req;
        adv       = !step_mode || edge_seen;
        m_ack     = 1'b0;
        m_wrap    = 1'b0;
        case (m_state)
            M_IDLE: if (start) begin
                m_state = M_RUN;
                m_sc    = 4'd0;
                m_cyc   = 16'd0;
                m_ins   = 16'd0;
                m_cyc4  = 4'd0;
                m_ins4  = 4'd0;
            end
            M_RUN: begin
                if (halt) begin
                    m_state = M_HALT;
                end else if (adv) begin
                    m_ack = step_mode;
                    if (m_cyc  != 16'hFFFF) m_cyc  = m_cyc + 16'd1;
                    if (m_cyc4 != 4'hF)     m_cyc4 = m_cyc4 + 4'd1;
                    if (sc_clr) begin
                        m_sc = 4'd0;
                        if (m_ins  != 16'hFFFF) m_ins  = m_ins + 16'd1;
                        if (m_ins4 != 4'hF)     m_ins4 = m_ins4 + 4'd1;
                    end else if (m_sc == 4'd15) begin
                        m_sc   = 4'd0;
                        m_wrap = 1'b1;
                    end else begin
                        m_sc = m_sc + 4'd1;
                    end
                end
            end
            default: if (start && !halt) m_state = M_RUN;
        endcase
    endtask

    // ---------------------------------------------------------------- checks
    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: model updates on the rising edge, DUT is checked on the
    // falling edge. Inputs are changed by the caller after this returns.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        e.sc   = m_sc;
        e.ack  = m_ack;
        e.wrap = m_wrap;
        e.run  = (m_state == M_RUN);
        e.hlt  = (m_state == M_HALT);
        e.cyc  = m_cyc;
        e.ins  = m_ins;
        e.cyc4 = m_cyc4;
        e.ins4 = m_ins4;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        cmp("sc",         32'(sc),         32'(e.sc));
        cmp("step_ack",   32'(step_ack),   32'(e.ack));
        cmp("sc_wrap",    32'(sc_wrap),    32'(e.wrap));
        cmp("running",    32'(running),    32'(e.run));
        cmp("halted",     32'(halted),     32'(e.hlt));
        cmp("cycle_cnt",  32'(cycle_cnt),  32'(e.cyc));
        cmp("instr_cnt",  32'(instr_cnt),  32'(e.ins));
        cmp("sc_w4",      32'(sc4),        32'(e.sc));
        cmp("cycle_cnt4", 32'(cycle_cnt4), 32'(e.cyc4));
        cmp("instr_cnt4", 32'(instr_cnt4), 32'(e.ins4));
        if (sc_wrap === 1'b1) n_wrap_seen++;
        if (step_ack === 1'b1) n_ack_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded run until the model reaches a timing state.
    task automatic run_until(input logic [3:0] target);
        for (int i = 0; i < 40 && m_sc != target; i++) tick();
        cmp("reach_sc", 32'(sc), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_sc"},       32'(sc),        32'd0);
        cmp({tag, "_ack"},      32'(step_ack),  32'd0);
        cmp({tag, "_wrap"},     32'(sc_wrap),   32'd0);
        cmp({tag, "_running"},  32'(running),   32'd0);
        cmp({tag, "_halted"},   32'(halted),    32'd0);
        cmp({tag, "_cycle"},    32'(cycle_cnt), 32'd0);
        cmp({tag, "_instr"},    32'(instr_cnt), 32'd0);
        cmp({tag, "_cycle4"},   32'(cycle_cnt4), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        halt      = 1'b0;
        sc_clr    = 1'b0;
        step_mode = 1'b0;
        step_req  = 1'b0;
        model_reset();

        // Reset state.
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores halt.
        halt = 1'b1;
        ticks(2);
        halt = 1'b0;

        // Free run: enter RUN at sc=0, then 20 advances.
        start = 1'b1;
        tick();
        start = 1'b0;
        n_wrap_seen = 0;
        ticks(20);
        cmp("free_cycle_cnt", 32'(cycle_cnt), 32'd20);
        cmp("free_wrap_once", 32'(n_wrap_seen), 32'd1);
        cmp("free_sc_end", 32'(sc), 32'd4);
        cmp("sat_cycle4", 32'(cycle_cnt4), 32'd15);

        // Instruction end at sc=3.
        run_until(4'd3);
        sc_clr = 1'b1;
        tick();
        sc_clr = 1'b0;
        cmp("clr_sc", 32'(sc), 32'd0);
        cmp("clr_instr", 32'(instr_cnt), 32'd1);
        cmp("clr_nowrap", 32'(sc_wrap), 32'd0);

        // halt and sc_clr together at sc=5: halt wins.
        run_until(4'd5);
        halt   = 1'b1;
        sc_clr = 1'b1;
        tick();
        sc_clr = 1'b0;
        cmp("hclr_halted", 32'(halted), 32'd1);
        cmp("hclr_sc", 32'(sc), 32'd5);
        cmp("hclr_instr", 32'(instr_cnt), 32'd1);

        // start with halt still high stays in HALT.
        start = 1'b1;
        tick();
        cmp("halt_start_stay", 32'(halted), 32'd1);
        halt = 1'b0;
        tick();
        start = 1'b0;

        // Halt at sc=7 for 10 cycles, then resume.
        run_until(4'd7);
        halt = 1'b1;
        ticks(10);
        halt = 1'b0;
        cmp("halt7_sc", 32'(sc), 32'd7);
        cmp("halt7_halted", 32'(halted), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        cmp("resume_running", 32'(running), 32'd1);
        cmp("resume_sc_hold", 32'(sc), 32'd7);
        tick();
        cmp("resume_sc8", 32'(sc), 32'd8);

        // Async reset between edges at sc=9.
        run_until(4'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("areset");
        model_reset();
        #1;
        rst_n = 1'b1;
        ticks(3);

        // Single step from a fresh start.
        step_mode = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        n_ack_seen = 0;
        step_req  = 1'b1;
        ticks(5);
        step_req  = 1'b0;
        ticks(2);
        step_req  = 1'b1;
        tick();
        step_req  = 1'b0;
        ticks(2);
        cmp("step_sc", 32'(sc), 32'd2);
        cmp("step_acks", 32'(n_ack_seen), 32'd2);
        cmp("step_cycle", 32'(cycle_cnt), 32'd2);

        // sc_clr without a step edge is ignored; with an edge it is taken.
        sc_clr = 1'b1;
        ticks(2);
        step_req = 1'b1;
        tick();
        sc_clr   = 1'b0;
        step_req = 1'b0;
        cmp("step_clr_sc", 32'(sc), 32'd0);
        cmp("step_clr_instr", 32'(instr_cnt), 32'd1);

        // Switch to step mode with a coincident request edge, then back.
        step_mode = 1'b0;
        ticks(3);
        step_mode = 1'b1;
        step_req  = 1'b1;
        tick();
        step_req  = 1'b0;
        ticks(2);
        step_mode = 1'b0;
        ticks(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
